// File: rtl/qmult_pkg.sv
// Shared definitions for the pipelined shift-add multiplier: width helpers,
// the per-stage payload layout at default widths, and the output saturation helpers.
package qmult_pkg;

    localparam int unsigned DEF_DATA_W = 13;
    localparam int unsigned DEF_K_W    = 3;
    localparam int unsigned DEF_OUT_W  = 13;
    localparam int unsigned DEF_TAG_W  = 8;

    // Width of the full product; the accumulator never overflows at this width.
    function automatic int unsigned prod_w(input int unsigned data_w, input int unsigned k_w);
        return data_w + k_w;
    endfunction

    typedef struct packed {
        logic                                       valid;
        logic [DEF_DATA_W-1:0]                      a;
        logic [DEF_K_W-1:0]                         k;
        logic [DEF_TAG_W-1:0]                       tag;
        logic [prod_w(DEF_DATA_W, DEF_K_W)-1:0]     acc;
    } stage_t;

    // Products are handled zero-extended to 64 bits, so prod_w() must stay below 64.
    function automatic logic sat_ovf(input logic [63:0] acc, input int unsigned out_w);
        return (acc >> out_w) != 64'd0;
    endfunction

    function automatic logic [63:0] sat_clip(input logic [63:0] acc, input int unsigned out_w,
                                             input bit sat);
        logic [63:0] mask;
        mask = (64'd1 << out_w) - 64'd1;
        if (sat && sat_ovf(acc, out_w)) begin
            return mask;
        end
        return acc & mask;
    endfunction

endpackage

// File: rtl/qmult_stage.sv
// One conditional shift-add stage: adds a << BIT when coefficient bit BIT is set,
// forwarding operand, coefficient, tag and valid alongside the accumulator.
module qmult_stage
    import qmult_pkg::*;
#(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned K_W    = 3,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned BIT    = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_en,
    input  logic                             i_valid,
    input  logic [DATA_W-1:0]                i_a,
    input  logic [K_W-1:0]                   i_k,
    input  logic [TAG_W-1:0]                 i_tag,
    input  logic [prod_w(DATA_W, K_W)-1:0]   i_acc,
    output logic                             o_valid,
    output logic [DATA_W-1:0]                o_a,
    output logic [K_W-1:0]                   o_k,
    output logic [TAG_W-1:0]                 o_tag,
    output logic [prod_w(DATA_W, K_W)-1:0]   o_acc
);

    localparam int unsigned PW = prod_w(DATA_W, K_W);

    logic [PW-1:0] addend;

    always_comb begin
        addend = '0;
        if (i_k[BIT]) begin
            addend = PW'(i_a) << BIT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_a     <= '0;
            o_k     <= '0;
            o_tag   <= '0;
            o_acc   <= '0;
        end else if (i_en) begin
            o_valid <= i_valid;
            o_a     <= i_a;
            o_k     <= i_k;
            o_tag   <= i_tag;
            o_acc   <= i_acc + addend;
        end
    end

endmodule

// File: rtl/qmult_pipe.sv
// Pipelined shift-add multiplier: DATA_W operand times K_W coefficient, one coefficient bit
// per stage, globally stalled by downstream backpressure, with optional output saturation.
module qmult_pipe
    import qmult_pkg::*;
#(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned K_W    = 3,
    parameter int unsigned OUT_W  = 13,
    parameter int unsigned TAG_W  = 8,
    parameter bit          SAT    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [K_W-1:0]    i_k,
    input  logic [TAG_W-1:0]  i_tag,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_sat,
    output logic [TAG_W-1:0]  o_tag
);

    localparam int unsigned PW = prod_w(DATA_W, K_W);

    logic en;

    logic              v0_q;
    logic [DATA_W-1:0] a0_q;
    logic [K_W-1:0]    k0_q;
    logic [TAG_W-1:0]  tag0_q;

    logic              v_p   [K_W+1];
    logic [DATA_W-1:0] a_p   [K_W+1];
    logic [K_W-1:0]    k_p   [K_W+1];
    logic [TAG_W-1:0]  tag_p [K_W+1];
    logic [PW-1:0]     acc_p [K_W+1];

    logic              out_valid_q;
    logic [OUT_W-1:0]  out_data_q;
    logic              out_sat_q;
    logic [TAG_W-1:0]  out_tag_q;

    logic [OUT_W-1:0]  res_d;
    logic              ovf_d;

    // A full output register with no taker freezes the whole pipe, input side included.
    assign en      = !out_valid_q || i_ready;
    assign o_ready = en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v0_q   <= 1'b0;
            a0_q   <= '0;
            k0_q   <= '0;
            tag0_q <= '0;
        end else if (en) begin
            v0_q   <= i_valid;
            a0_q   <= i_data;
            k0_q   <= i_k;
            tag0_q <= i_tag;
        end
    end

    assign v_p[0]   = v0_q;
    assign a_p[0]   = a0_q;
    assign k_p[0]   = k0_q;
    assign tag_p[0] = tag0_q;
    assign acc_p[0] = '0;

    for (genvar i = 1; i <= K_W; i++) begin : g_stage
        qmult_stage #(
            .DATA_W (DATA_W),
            .K_W    (K_W),
            .TAG_W  (TAG_W),
            .BIT    (i - 1)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (en),
            .i_valid (v_p[i-1]),
            .i_a     (a_p[i-1]),
            .i_k     (k_p[i-1]),
            .i_tag   (tag_p[i-1]),
            .i_acc   (acc_p[i-1]),
            .o_valid (v_p[i]),
            .o_a     (a_p[i]),
            .o_k     (k_p[i]),
            .o_tag   (tag_p[i]),
            .o_acc   (acc_p[i])
        );
    end

    // Operand and coefficient are no longer needed once the last stage has added its term.
    logic unused_tail;
    assign unused_tail = ^{a_p[K_W], k_p[K_W]};

    always_comb begin
        ovf_d = sat_ovf(64'(acc_p[K_W]), OUT_W);
        res_d = OUT_W'(sat_clip(64'(acc_p[K_W]), OUT_W, SAT));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_tag_q   <= '0;
        end else if (en) begin
            out_valid_q <= v_p[K_W];
            out_data_q  <= res_d;
            out_sat_q   <= ovf_d;
            out_tag_q   <= tag_p[K_W];
        end
    end

    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;
    assign o_sat   = out_sat_q;
    assign o_tag   = out_tag_q;

endmodule
